ad_pingpong_buf: RTL and testbench

// - ADC sample ping-pong buffer between the ADC front end and the USB command/TX stage.
// - Stores samples of the selected channel into one bank while the other bank is read out.
// - Pulses ad_switch when a bank fills, then serves that bank's words to the TX framer via ad_rd/ad_data.

---
 rtl/ad_pingpong_buf_pkg.sv | 7 +
 rtl/ad_pingpong_buf_if.sv | 26 ++
 rtl/ad_dpram.sv | 22 ++
 rtl/ad_pingpong_buf.sv | 81 ++++++++
 tb/tb_ad_pingpong_buf.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ad_pingpong_buf_pkg.sv
// Shared sizing for the ADC ping-pong buffer (mirrors the legacy globals.v defines).
package ad_pingpong_buf_pkg;
  localparam int AD_DATA_NBIT     = 16;
  localparam int AD_CHN_NBIT      = 3;
  localparam int AD_CHE_DATA_SIZE = 511;
  localparam int AD_BANK_DEPTH    = AD_CHE_DATA_SIZE + 1;
endpackage

// File: rtl/ad_pingpong_buf_if.sv
// Front-end sample stream plus TX-framer read port of the ping-pong buffer.
interface ad_pingpong_buf_if
  import ad_pingpong_buf_pkg::*;
#(
  parameter int P_DATA_NBIT = AD_DATA_NBIT,
  parameter int P_CHN_NBIT  = AD_CHN_NBIT
);
  logic                   acq_en;
  logic [P_CHN_NBIT-1:0]  ad_chn;
  logic                   smp_vd;
  logic [P_CHN_NBIT-1:0]  smp_chn;
  logic [P_DATA_NBIT-1:0] smp_data;
  logic                   ad_rd;
  logic [P_DATA_NBIT-1:0] ad_data;
  logic                   ad_switch;
  logic                   ad_ovf;

  modport master (
    output acq_en, ad_chn, smp_vd, smp_chn, smp_data, ad_rd,
    input  ad_data, ad_switch, ad_ovf
  );
  modport slave (
    input  acq_en, ad_chn, smp_vd, smp_chn, smp_data, ad_rd,
    output ad_data, ad_switch, ad_ovf
  );
endinterface

// File: rtl/ad_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (output reset to 0).
module ad_dpram #(
  parameter int P_DATA_NBIT = 16,
  parameter int P_AW        = 10
) (
  input  logic                   mclk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [P_AW-1:0]        waddr,
  input  logic [P_DATA_NBIT-1:0] wdata,
  input  logic [P_AW-1:0]        raddr,
  output logic [P_DATA_NBIT-1:0] rdata
);
  logic [P_DATA_NBIT-1:0] mem [2**P_AW];

  always_ff @(posedge mclk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
endmodule

// File: rtl/ad_pingpong_buf.sv
// ADC ping-pong buffer: fills one bank with the selected channel while the framer
// drains the other; flags a bank overwritten mid-readout.
module ad_pingpong_buf
  import ad_pingpong_buf_pkg::*;
#(
  parameter int P_DATA_NBIT = AD_DATA_NBIT,
  parameter int P_CHN_NBIT  = AD_CHN_NBIT,
  parameter int P_DEPTH     = AD_BANK_DEPTH
) (
  input logic         mclk,
  input logic         rst_n,
  ad_pingpong_buf_if.slave bus
);
  localparam int            AW       = $clog2(P_DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(P_DEPTH - 1);

  logic [P_CHN_NBIT-1:0] chn_q;
  logic                  wr_bank, rd_bank, rd_bank_nxt;
  logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic                  rd_busy, rd_busy_nxt;
  logic                  sw_q, ovf_q;
  logic                  chn_chg, acc, full;

  assign chn_chg = bus.ad_chn != chn_q;
  assign acc     = bus.acq_en & bus.smp_vd & (bus.smp_chn == bus.ad_chn) & ~chn_chg;
  assign full    = acc & (wr_ptr == PTR_LAST);

  // Pop lands on the current bank first; a bank switch in the same cycle then wins.
  always_comb begin
    rd_bank_nxt = rd_bank;
    rd_ptr_nxt  = rd_ptr;
    rd_busy_nxt = rd_busy;
    if (bus.ad_rd && rd_busy) begin
      if (rd_ptr != PTR_LAST) rd_ptr_nxt = rd_ptr + AW'(1);
      if (rd_ptr_nxt == PTR_LAST) rd_busy_nxt = 1'b0;
    end
    if (full) begin
      rd_bank_nxt = wr_bank;
      rd_ptr_nxt  = '0;
      rd_busy_nxt = 1'b1;
    end
  end

  // chn_q resets to 0, so a nonzero ad_chn restarts the fill on the first cycle.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      chn_q   <= '0;
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      rd_bank <= 1'b1;
      rd_ptr  <= '0;
      rd_busy <= 1'b0;
      sw_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      chn_q <= bus.ad_chn;
      sw_q  <= full;
      if (full && rd_busy) ovf_q <= 1'b1;
      if (!bus.acq_en || chn_chg) wr_ptr <= '0;
      else if (acc)               wr_ptr <= wr_ptr + AW'(1);
      if (full) wr_bank <= ~wr_bank;
      rd_bank <= rd_bank_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rd_busy <= rd_busy_nxt;
    end
  end

  assign bus.ad_switch = sw_q;
  assign bus.ad_ovf    = ovf_q;

  // Read address uses the next pointer so ad_data is already the head word.
  ad_dpram #(.P_DATA_NBIT(P_DATA_NBIT), .P_AW(AW + 1)) u_ram (
    .mclk  (mclk),
    .rst_n (rst_n),
    .we    (acc),
    .waddr ({wr_bank, wr_ptr}),
    .wdata (bus.smp_data),
    .raddr ({rd_bank_nxt, rd_ptr_nxt}),
    .rdata (bus.ad_data)
  );
endmodule

// File: tb/tb_ad_pingpong_buf.sv
// Frame-level reference model of the ping-pong buffer, directed cases then random traffic.
module tb_ad_pingpong_buf;
  localparam int D = 8;

  logic mclk = 1'b0;
  logic rst_n = 1'b1;
  always #5 mclk = ~mclk;

  ad_pingpong_buf_if #(.P_DATA_NBIT(16), .P_CHN_NBIT(3)) bus ();

  ad_pingpong_buf #(.P_DATA_NBIT(16), .P_CHN_NBIT(3), .P_DEPTH(D)) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nchk = 0, nerr = 0, nsw = 0;

  // model: samples collected for the frame in progress, frame under readout
  logic [15:0] wq[$];
  logic [15:0] rf[D];
  int          m_ridx;
  bit          m_busy, m_ovf, m_sw, m_rv;
  logic [2:0]  m_pchn;

  bit         c_acq;
  logic [2:0] c_chn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic mrst();
    wq.delete();
    m_ridx = 0; m_busy = 0; m_ovf = 0; m_sw = 0; m_rv = 0; m_pchn = 3'd0;
  endtask

  task automatic mdl(input bit acq, input logic [2:0] chn, input bit vd,
                     input logic [2:0] schn, input logic [15:0] d, input bit rd);
    bit was_busy = m_busy;
    bit full = 0;
    m_sw = 0;
    if (!acq || chn != m_pchn) wq.delete();
    else if (vd && schn == chn) begin
      wq.push_back(d);
      full = (wq.size() == D);
    end
    m_pchn = chn;
    if (rd && m_busy) begin
      if (m_ridx < D - 1) m_ridx++;
      if (m_ridx == D - 1) m_busy = 0;
    end
    if (full) begin
      if (was_busy) m_ovf = 1;
      foreach (rf[i]) rf[i] = wq[i];
      wq.delete();
      m_ridx = 0; m_busy = 1; m_sw = 1; m_rv = 1;
    end
  endtask

  task automatic step(input bit acq, input logic [2:0] chn, input bit vd,
                      input logic [2:0] schn, input logic [15:0] d, input bit rd);
    @(negedge mclk);
    bus.acq_en = acq; bus.ad_chn = chn; bus.smp_vd = vd;
    bus.smp_chn = schn; bus.smp_data = d; bus.ad_rd = rd;
    @(posedge mclk);
    mdl(acq, chn, vd, schn, d, rd);
    #1;
    if (bus.ad_switch) nsw++;
    chk("switch", 32'(bus.ad_switch), 32'(m_sw));
    chk("ovf", 32'(bus.ad_ovf), 32'(m_ovf));
    if (m_rv && !m_sw) chk("data", 32'(bus.ad_data), 32'(rf[m_ridx]));
  endtask

  task automatic smp(input logic [15:0] d, input logic [2:0] ch = 3'd2, input bit rd = 0);
    step(c_acq, c_chn, 1'b1, ch, d, rd);
  endtask

  task automatic idle(input bit rd = 0);
    step(c_acq, c_chn, 1'b0, 3'd0, 16'h0, rd);
  endtask

  task automatic frame(input logic [15:0] base);
    for (int i = 0; i < D; i++) smp(base + 16'(i));
  endtask

  // expects the word-0 cycle already reached; pops through and one past the end
  task automatic rd_frame(input logic [15:0] base);
    chk("rd_w0", 32'(bus.ad_data), 32'(base));
    for (int i = 1; i < D; i++) begin
      idle(1);
      chk("rd_wn", 32'(bus.ad_data), 32'(base + 16'(i)));
    end
    idle(1);
    chk("rd_sat", 32'(bus.ad_data), 32'(base + 16'(D - 1)));
  endtask

  task automatic do_rst();
    @(negedge mclk);
    bus.smp_vd = 0; bus.ad_rd = 0;
    rst_n = 1'b0;
    #1;
    mrst();
    chk("rst_data", 32'(bus.ad_data), 32'h0);
    chk("rst_sw", 32'(bus.ad_switch), 32'h0);
    chk("rst_ovf", 32'(bus.ad_ovf), 32'h0);
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    c_acq = 1; c_chn = 3'd2;
    bus.acq_en = 1; bus.ad_chn = 3'd2; bus.smp_vd = 0;
    bus.smp_chn = 0; bus.smp_data = 0; bus.ad_rd = 0;
    #1;
    do_rst();
    repeat (3) idle();

    // single frame, readout
    n0 = nsw;
    frame(16'h0100);
    chk("sw_after8", 32'(bus.ad_switch), 32'h1);
    idle();
    chk("sw_once", 32'(nsw - n0), 32'h1);
    rd_frame(16'h0100);

    // interleaved channels: only chn 2 lands
    n0 = nsw;
    for (int i = 0; i < 2 * D; i++)
      if (i % 2 == 0) smp(16'h0900 + 16'(i), 3'd1);
      else            smp(16'h0300 + 16'(i / 2), 3'd2);
    idle();
    chk("ilv_sw", 32'(nsw - n0), 32'h1);
    rd_frame(16'h0300);

    // partial bank discarded by acq_en low
    n0 = nsw;
    for (int i = 0; i < 5; i++) smp(16'h0250 + 16'(i));
    c_acq = 0;
    repeat (3) idle();
    c_acq = 1;
    idle();
    chk("acq_nosw", 32'(nsw - n0), 32'h0);
    frame(16'h0200);
    idle();
    chk("acq_sw", 32'(nsw - n0), 32'h1);
    rd_frame(16'h0200);

    // two frames, no reads: overflow, newest frame wins
    frame(16'h0400);
    chk("ovf_pre", 32'(bus.ad_ovf), 32'h0);
    frame(16'h0500);
    chk("ovf_set", 32'(bus.ad_ovf), 32'h1);
    idle();
    rd_frame(16'h0500);
    repeat (4) idle();
    chk("ovf_sticky", 32'(bus.ad_ovf), 32'h1);

    // bank-full coincident with a pop
    frame(16'h0600);
    idle();
    for (int i = 0; i < D; i++) smp(16'h0700 + 16'(i), 3'd2, (i < 3) || (i == D - 1));
    idle();
    chk("coinc_w0", 32'(bus.ad_data), 32'h0700);
    idle(1);
    chk("coinc_w1", 32'(bus.ad_data), 32'h0701);
    idle(1);
    chk("coinc_w2", 32'(bus.ad_data), 32'h0702);
    repeat (6) idle(1);

    // reset mid-readout, then a clean frame
    frame(16'h0800);
    idle();
    repeat (3) idle(1);
    chk("mid_w3", 32'(bus.ad_data), 32'h0803);
    do_rst();
    repeat (3) idle();
    n0 = nsw;
    frame(16'h0100);
    chk("post_sw", 32'(bus.ad_switch), 32'h1);
    idle();
    chk("post_once", 32'(nsw - n0), 32'h1);
    rd_frame(16'h0100);
    chk("post_ovf", 32'(bus.ad_ovf), 32'h0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] sc;
      if ($urandom_range(99) < 2) c_chn = 3'($urandom_range(3, 1));
      c_acq = $urandom_range(99) >= 5;
      sc = ($urandom_range(3) == 0) ? 3'($urandom_range(3, 1)) : c_chn;
      step(c_acq, c_chn, $urandom_range(99) < 60, sc, 16'($urandom), $urandom_range(99) < 30);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
